// File: rtl/dmi_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_access_ctrl
//  Purpose  : DTM-side DMI access controller. It turns TAP DMI scans into DM
//             requests, collects the responses and tracks the sticky DMI error.
//  Revision : 1.0 - initial release
// ============================================================================
module dmi_access_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             capture_i,
  input  logic                             update_i,
  input  logic                             dmireset_i,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] dr_i,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] dr_o,
  output logic                             dmi_req_valid_o,
  input  logic                             dmi_req_ready_i,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] dmi_req_o,
  input  logic                             dmi_resp_valid_i,
  output logic                             dmi_resp_ready_o,
  input  logic [DATA_WIDTH+1:0]            dmi_resp_i,
  output logic [1:0]                       dmi_error_o
);

  localparam logic [1:0] c_OP_READ      = 2'd1;
  localparam logic [1:0] c_OP_WRITE     = 2'd2;
  localparam logic [1:0] c_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] c_ERR_NONE     = 2'd0;
  localparam logic [1:0] c_ERR_FAILED   = 2'd2;
  localparam logic [1:0] c_ERR_BUSY     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ       = 3'd1,
    S_WRITE      = 3'd2,
    S_WAIT_READ  = 3'd3,
    S_WAIT_WRITE = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_error;
  logic [1:0]              w_error_next;
  logic [ADDR_WIDTH+DATA_WIDTH+1:0] r_dr;

  logic [ADDR_WIDTH-1:0]   w_dr_addr;
  logic [DATA_WIDTH-1:0]   w_dr_data;
  logic [1:0]              w_dr_op;
  logic [DATA_WIDTH-1:0]   w_resp_data;
  logic [1:0]              w_resp_code;
  logic [1:0]              w_err_eff;
  logic [1:0]              w_status;
  logic                    w_idle;
  logic                    w_wait;
  logic                    w_accept;

  assign w_dr_addr   = dr_i[ADDR_WIDTH+DATA_WIDTH+1:DATA_WIDTH+2];
  assign w_dr_data   = dr_i[DATA_WIDTH+1:2];
  assign w_dr_op     = dr_i[1:0];
  assign w_resp_data = dmi_resp_i[DATA_WIDTH+1:2];
  assign w_resp_code = dmi_resp_i[1:0];

  assign w_idle = (r_state == S_IDLE);
  assign w_wait = (r_state == S_WAIT_READ) || (r_state == S_WAIT_WRITE);

  // dmireset wins over everything else seen in the same cycle
  assign w_err_eff = dmireset_i ? c_ERR_NONE : r_error;
  assign w_accept  = w_idle && update_i && (w_err_eff == c_ERR_NONE) &&
                     ((w_dr_op == c_OP_READ) || (w_dr_op == c_OP_WRITE));
  assign w_status  = (w_err_eff != c_ERR_NONE) ? w_err_eff :
                     (!w_idle ? c_ERR_BUSY : c_ERR_NONE);

  assign dr_o        = r_dr;
  assign dmi_error_o = r_error;

  always_comb begin
    w_state_next     = r_state;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_dr_op == c_OP_READ) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) w_state_next = S_WAIT_READ;
      end
      S_WRITE: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) w_state_next = S_WAIT_WRITE;
      end
      S_WAIT_READ, S_WAIT_WRITE: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dmi_req_o = '0;
    if (r_state == S_READ) begin
      dmi_req_o = {r_addr, c_OP_READ, {DATA_WIDTH{1'b0}}};
    end else if (r_state == S_WRITE) begin
      dmi_req_o = {r_addr, c_OP_WRITE, r_data};
    end
  end

  // First error wins: only a clear error state can take busy or failed
  always_comb begin
    w_error_next = w_err_eff;
    if (w_err_eff == c_ERR_NONE) begin
      if (!w_idle && !dmireset_i && (update_i || capture_i)) begin
        w_error_next = c_ERR_BUSY;
      end else if (w_wait && dmi_resp_valid_i && (w_resp_code != c_RESP_SUCCESS)) begin
        w_error_next = c_ERR_FAILED;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_error <= c_ERR_NONE;
      r_dr    <= '0;
    end else begin
      r_state <= w_state_next;
      r_error <= w_error_next;
      if (w_accept) begin
        r_addr <= w_dr_addr;
        if (w_dr_op == c_OP_WRITE) r_data <= w_dr_data;
      end
      if ((r_state == S_WAIT_READ) && dmi_resp_valid_i) begin
        r_data <= w_resp_data;
      end
      if (capture_i) begin
        r_dr <= {r_addr, r_data, w_status};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmi_access_ctrl
//  Purpose  : Scoreboard bench for dmi_access_ctrl with a transaction-level
//             model of the DMI register and a randomised DM responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture_i = 1'b0;
  logic        update_i = 1'b0;
  logic        dmireset_i = 1'b0;
  logic [40:0] dr_i = '0;
  logic [40:0] dr_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [33:0] dmi_resp_i;
  logic [1:0]  dmi_error_o;

  dmi_access_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .capture_i        (capture_i),
    .update_i         (update_i),
    .dmireset_i       (dmireset_i),
    .dr_i             (dr_i),
    .dr_o             (dr_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_error_o      (dmi_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  code;
    int          rdly;
    int          sdly;
    bit          no_accept;
  } plan_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  plan_t       plan_q[$];
  logic [40:0] exp_req_q[$];
  logic [40:0] exp_cap_q[$];
  int          resp_done = 0;
  int          n_issued  = 0;

  // Abstract view of the DMI register as seen from the scan side
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_err  = '0;
  bit          in_flight = 1'b0;
  logic [1:0]  pend_op;
  plan_t       pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          cap_pending = 1'b0;
  bit          prev_wait   = 1'b0;
  logic [40:0] prev_payload;

  always @(negedge clk) begin
    if (rst) begin
      cap_pending = 1'b0;
      prev_wait   = 1'b0;
    end else begin
      if (cap_pending) begin
        if (exp_cap_q.size() == 0) begin
          n_checks++;
          $display("FAIL capture_unexpected: dr_o 0x%0h with nothing expected", dr_o);
        end else begin
          check("dr_o", {23'd0, dr_o}, {23'd0, exp_cap_q.pop_front()});
        end
        cap_pending = 1'b0;
      end
      if (capture_i) cap_pending = 1'b1;
      if (prev_wait) begin
        check("req_hold_valid", {63'd0, dmi_req_valid_o}, 64'd1);
        check("req_hold_payload", {23'd0, dmi_req_o}, {23'd0, prev_payload});
      end
      prev_wait    = dmi_req_valid_o && !dmi_req_ready_i;
      prev_payload = dmi_req_o;
      if (dmi_req_valid_o && dmi_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_unexpected: request 0x%0h with nothing expected", dmi_req_o);
        end else begin
          check("dmi_req", {23'd0, dmi_req_o}, {23'd0, exp_req_q.pop_front()});
        end
      end
    end
  end

  // ---------------- DM responder ----------------
  initial begin
    plan_t p;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    forever begin
      tick();
      if (!rst && dmi_req_valid_o && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        repeat (p.rdly) tick();
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        repeat (p.sdly) tick();
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = {p.data, p.code};
        @(negedge clk);
        if (p.no_accept) check("resp_ready_outside_wait", {63'd0, dmi_resp_ready_o}, 64'd0);
        else             check("resp_ready_in_wait", {63'd0, dmi_resp_ready_o}, 64'd1);
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = {32'($urandom), 2'b01};
        resp_done++;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_update(input logic [1:0] op, input logic [6:0] addr,
                           input logic [31:0] data, input bit drst, input plan_t p);
    update_i   = 1'b1;
    dr_i       = {addr, data, op};
    dmireset_i = drst;
    if (drst) m_err = 2'd0;
    if (in_flight) begin
      if (!drst && m_err == 2'd0) m_err = 2'd3;
    end else if (m_err == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
      m_addr = addr;
      if (op == 2'd2) m_data = data;
      exp_req_q.push_back({addr, op, (op == 2'd2) ? data : 32'h0});
      plan_q.push_back(p);
      pend      = p;
      pend_op   = op;
      in_flight = 1'b1;
      n_issued++;
    end
    tick();
    update_i   = 1'b0;
    dmireset_i = 1'b0;
    dr_i       = {7'($urandom), 32'($urandom), 2'($urandom)};
  endtask

  task automatic do_capture(input bit drst);
    capture_i  = 1'b1;
    dmireset_i = drst;
    if (drst) m_err = 2'd0;
    exp_cap_q.push_back({m_addr, m_data, (m_err != 2'd0) ? m_err : (in_flight ? 2'd3 : 2'd0)});
    if (in_flight && !drst && m_err == 2'd0) m_err = 2'd3;
    tick();
    capture_i  = 1'b0;
    dmireset_i = 1'b0;
  endtask

  task automatic do_dmireset();
    dmireset_i = 1'b1;
    m_err      = 2'd0;
    tick();
    dmireset_i = 1'b0;
  endtask

  task automatic finish_access();
    int t = 0;
    if (in_flight) begin
      while (resp_done < n_issued && t < 300) begin
        tick();
        t++;
      end
      if (resp_done < n_issued) begin
        n_checks++;
        $display("FAIL access_timeout: responses %0d, required %0d", resp_done, n_issued);
      end else begin
        if (pend_op == 2'd1) m_data = pend.data;
        if (m_err == 2'd0 && pend.code != 2'd0) m_err = 2'd2;
      end
      in_flight = 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_error"}, {62'd0, dmi_error_o}, {62'd0, m_err});
    check({name, "_valid"}, {63'd0, dmi_req_valid_o}, 64'd0);
  endtask

  function automatic plan_t mk_plan(input logic [31:0] d, input logic [1:0] c,
                                    input int rd, input int sd);
    plan_t p;
    p.data = d; p.code = c; p.rdly = rd; p.sdly = sd; p.no_accept = 1'b0;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    plan_t p;
    bit    b;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dr_o", {23'd0, dr_o}, 64'd0);
    check("reset_error", {62'd0, dmi_error_o}, 64'd0);
    check("reset_req_valid", {63'd0, dmi_req_valid_o}, 64'd0);
    check("reset_resp_ready", {63'd0, dmi_resp_ready_o}, 64'd0);
    rst = 1'b0;
    tick();

    // read with immediate ready
    do_update(2'd1, 7'h11, 32'h1234_5678, 1'b0, mk_plan(32'hDEAD_BEEF, 2'd0, 0, 2));
    finish_access();
    check_idle("read");
    do_capture(1'b0);

    // write with backpressure
    do_update(2'd2, 7'h04, 32'hCAFE_F00D, 1'b0, mk_plan(32'h5555_AAAA, 2'd0, 5, 1));
    finish_access();
    check_idle("write");
    do_capture(1'b0);

    // busy: capture during access, later scans ignored until dmireset
    do_update(2'd1, 7'h22, 32'h0, 1'b0, mk_plan(32'h0BAD_F00D, 2'd0, 1, 3));
    do_capture(1'b0);
    finish_access();
    check_idle("busy");
    do_update(2'd2, 7'h33, 32'h7777_7777, 1'b0, mk_plan(32'h0, 2'd0, 0, 0));
    repeat (3) tick();
    do_capture(1'b0);
    do_dmireset();
    check_idle("busy_cleared");
    do_update(2'd1, 7'h33, 32'h0, 1'b0, mk_plan(32'h1357_9BDF, 2'd0, 0, 0));
    finish_access();
    do_capture(1'b0);

    // failed response
    do_update(2'd1, 7'h05, 32'h0, 1'b0, mk_plan(32'hFEED_FACE, 2'd2, 2, 2));
    finish_access();
    check_idle("failed");
    do_capture(1'b0);
    do_dmireset();
    check_idle("failed_cleared");

    // NOP and reserved op
    do_update(2'd0, 7'h6A, 32'h1111_2222, 1'b0, mk_plan(32'h0, 2'd0, 0, 0));
    do_update(2'd3, 7'h15, 32'h3333_4444, 1'b0, mk_plan(32'h0, 2'd0, 0, 0));
    check_idle("nop");
    do_capture(1'b0);

    // randomised traffic
    for (int i = 0; i < 150; i++) begin
      p.data = $urandom;
      p.code = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      p.rdly = $urandom_range(0, 4);
      p.sdly = $urandom_range(0, 4);
      p.no_accept = 1'b0;
      do_update(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                ($urandom_range(0, 9) == 0), p);
      if (in_flight && $urandom_range(0, 2) == 0) begin
        b = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 0) do_capture(b);
        else do_update(2'($urandom_range(0, 3)), 7'($urandom), $urandom, b, p);
      end
      finish_access();
      check({63'd0, 1'b0} == 64'd0 ? "rand_error" : "rand_error", {62'd0, dmi_error_o}, {62'd0, m_err});
      if ($urandom_range(0, 2) == 0) do_capture($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) do_dmireset();
    end

    // reset while waiting for a read response
    p = mk_plan(32'hA5A5_A5A5, 2'd0, 0, 40);
    p.no_accept = 1'b1;
    do_update(2'd1, 7'h4C, 32'h0, 1'b1, p);
    do_capture(1'b0);
    tick();
    check("wait_resp_ready", {63'd0, dmi_resp_ready_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_valid", {63'd0, dmi_req_valid_o}, 64'd0);
    check("rst_resp_ready", {63'd0, dmi_resp_ready_o}, 64'd0);
    check("rst_error", {62'd0, dmi_error_o}, 64'd0);
    check("rst_dr_o", {23'd0, dr_o}, 64'd0);
    check("rst_req", {23'd0, dmi_req_o}, 64'd0);
    m_addr = '0; m_data = '0; m_err = '0; in_flight = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_idle("after_reset");
    do_capture(1'b0);
    for (int t = 0; t < 100 && resp_done < n_issued; t++) tick();
    check("late_resp_done", 64'(resp_done), 64'(n_issued));
    repeat (3) tick();

    check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("cap_queue_empty", 64'(exp_cap_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
